jtag_stream_arbiter: RTL
========================

Name: jtag_stream_arbiter

Overview:
Shares one 32-bit JTAG shift engine between two AXI-Stream command sources (e.g. PS-side XVC and PL-side scan controller).
- Each 64-bit command beat carries TMS in [31:0] and TDI in [63:32].
- The block arbitrates round-robin at packet (TLAST) granularity and sequences the engine's reset/enable/done handshake.
- The captured 32-bit TDO is returned on the response stream belonging to the granted source.

Parameters:
C_S_AXIS_DATA_WIDTH, 64, command beat width; only [63:0] used, must be >= 64
C_TIMEOUT_CYCLES, 4096, max cycles in RUN awaiting ENG_DONE before abort (>= 2)

Ports:
CLK  in  1  single clock for all logic
RESETN  in  1  synchronous, active-low reset
S0_AXIS_TVALID  in  1  source 0 command valid
S0_AXIS_TREADY  out  1  source 0 command ready
S0_AXIS_TDATA  in  C_S_AXIS_DATA_WIDTH  source 0 command {TDI,TMS}
S0_AXIS_TLAST  in  1  source 0 end of packet
S1_AXIS_TVALID/TREADY/TDATA/TLAST  same as S0, for source 1
M0_AXIS_TVALID  out  1  source 0 TDO response valid
M0_AXIS_TREADY  in  1  source 0 response ready
M0_AXIS_TDATA  out  32  TDO vector
M0_AXIS_TLAST  out  1  copy of the command beat's TLAST
M1_AXIS_TVALID/TREADY/TDATA/TLAST  same as M0, for source 1
ENG_RESET  out  1  one-cycle engine reset pulse before each shift
ENG_ENABLE  out  1  engine run enable; held until done or timeout
ENG_DONE  in  1  engine completion pulse; TDO_VECTOR valid in the same cycle
TMS_VECTOR  out  32  TMS bits to engine
TDI_VECTOR  out  32  TDI bits to engine
TDO_VECTOR  in  32  TDO bits from engine
GRANT  out  2  one-hot current owner; 00 when unlocked
TIMEOUT_ERR  out  1  sticky timeout flag
CLR_ERR  in  1  clears TIMEOUT_ERR

Behaviour:
Reset (RESETN=0 at a CLK edge):
- All outputs go to 0; state=IDLE; lock cleared; round-robin pointer favours S0.
- Reset mid-operation drops the in-flight beat; no response is produced for it.

States: IDLE, RST, RUN, RESP.

IDLE:
- Unlocked: select a valid source, pointer-preferred on a tie.
- Locked: only the owner is eligible.
- Sx_TREADY is combinational: (state==IDLE) && selected==x. At most one TREADY is high at a time.
- On handshake: register TMS<=TDATA[31:0], TDI<=TDATA[63:32], last_r<=TLAST; set lock and GRANT to x; go to RST.

RST:
- ENG_RESET=1, ENG_ENABLE=0 for exactly one cycle; go to RUN.

RUN:
- ENG_ENABLE=1; timeout counter increments from 0.
- ENG_DONE=1: capture TDO_VECTOR; ENABLE<=0; go to RESP.
- Counter == C_TIMEOUT_CYCLES-1 without DONE: TDO<=0; set TIMEOUT_ERR; ENABLE<=0; go to RESP.
- DONE and timeout in the same cycle: DONE wins; no error is set.

RESP:
- Mx_TVALID=1; TDATA/TLAST held stable until Mx_TREADY.
- On handshake, if last_r: clear lock, GRANT<=00, pointer<=other source.
- Then go to IDLE.

Latency:
- Beat accepted at cycle t → ENG_RESET at t+1, ENABLE from t+2.
- DONE at t+2+k → TVALID at t+3+k.
- Minimum 4 cycles per beat.

General rules:
- ENG_DONE outside RUN is ignored.
- TMS_VECTOR/TDI_VECTOR keep their last value between beats.
- The non-granted M stream's TVALID stays 0.
- Back-pressure on Mx stalls the whole block; the other source waits.
- TIMEOUT_ERR is sticky until CLR_ERR=1. A timeout in the same cycle as CLR_ERR leaves it set.
- A packet cannot be pre-empted; the other source waits for its TLAST response handshake.

Decomposition:
- Package jtag_arb_pkg holds:
  - state encoding (IDLE/RST/RUN/RESP, one-hot)
  - TMS/TDI field offsets (0, 32) and vector width 32
  - default timeout constant
- Sub-module jtag_rr_arb2: 2-requester round-robin with packet lock.
  - Inputs: req[1:0], lock_set, release.
  - Outputs: sel and the one-hot grant.
- The top level holds the FSM, datapath registers and timeout counter.

Test Plan:
1. S0 single beat, TDATA=0xAAAA5555_0000FFFF, TLAST=1; engine returns DONE after 5 cycles with TDO=0x12345678 → TMS=0x0000FFFF, TDI=0xAAAA5555; ENG_RESET 1 cycle then ENABLE; M0 TVALID with 0x12345678, TLAST=1; M1 silent; GRANT 01→00.
2. S0 and S1 both valid from reset, each a 1-beat packet → S0 served first, then S1, then S0 again (pointer alternates); TREADY never high on both.
3. S1 sends a 3-beat packet while S0 is valid → all 3 S1 beats complete (GRANT=10 throughout) before S0 is accepted; M1 TLAST only on beat 3.
4. Engine never asserts DONE, C_TIMEOUT_CYCLES=16 → ENABLE drops after 16 RUN cycles; M0 TDATA=0; TIMEOUT_ERR=1 stays high until CLR_ERR pulse, then 0.
5. M0_TREADY held low 10 cycles in RESP → TVALID/TDATA stable; S1 TREADY stays 0 despite TVALID.
6. RESETN low for 1 cycle during RUN → all outputs 0 next cycle; no M response for the dropped beat; next S0 beat processed normally.

Source files
------------

// File: rtl/jtag_arb_pkg.sv
// Shared constants for the JTAG stream arbiter: FSM encoding, command field
// layout and the default engine timeout.
package jtag_arb_pkg;

  localparam int VEC_W           = 32;
  localparam int TMS_LSB         = 0;
  localparam int TDI_LSB         = 32;
  localparam int DEFAULT_TIMEOUT = 4096;

  localparam logic [3:0] ST_IDLE = 4'b0001;
  localparam logic [3:0] ST_RST  = 4'b0010;
  localparam logic [3:0] ST_RUN  = 4'b0100;
  localparam logic [3:0] ST_RESP = 4'b1000;

endpackage

// File: rtl/jtag_rr_arb2.sv
// Two-requester round-robin arbiter. Once a packet starts, the lock keeps the
// owner selected until the packet's final response releases it.
module jtag_rr_arb2 (
  input  logic       clk,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       lock_set,
  input  logic       lock_release,
  output logic       sel_valid,
  output logic       sel,
  output logic [1:0] grant
);

  logic ptr;
  logic locked;
  logic owner;

  always_comb begin
    sel       = ptr;
    sel_valid = 1'b0;
    if (locked) begin
      sel       = owner;
      sel_valid = req[owner];
    end else if (req[ptr]) begin
      sel       = ptr;
      sel_valid = 1'b1;
    end else if (req[!ptr]) begin
      sel       = !ptr;
      sel_valid = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr    <= 1'b0;
      locked <= 1'b0;
      owner  <= 1'b0;
    end else if (lock_set) begin
      locked <= 1'b1;
      owner  <= sel;
    end else if (lock_release) begin
      locked <= 1'b0;
      // The source that just finished a packet yields priority.
      ptr    <= !owner;
    end
  end

  assign grant = locked ? (owner ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: rtl/jtag_stream_arbiter.sv
// Shares one 32-bit JTAG shift engine between two AXI-Stream command sources
// and returns each captured TDO vector on the owning source's response stream.
//
// state | meaning
// IDLE  | wait for a command beat from the eligible source
// RST   | one-cycle engine reset pulse
// RUN   | engine enabled, waiting for ENG_DONE or timeout
// RESP  | present TDO on the owner's response stream until accepted
module jtag_stream_arbiter
  import jtag_arb_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH = 64,
  parameter int C_TIMEOUT_CYCLES    = DEFAULT_TIMEOUT
) (
  input  logic                           CLK,
  input  logic                           RESETN,
  input  logic                           S0_AXIS_TVALID,
  output logic                           S0_AXIS_TREADY,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] S0_AXIS_TDATA,
  input  logic                           S0_AXIS_TLAST,
  input  logic                           S1_AXIS_TVALID,
  output logic                           S1_AXIS_TREADY,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0] S1_AXIS_TDATA,
  input  logic                           S1_AXIS_TLAST,
  output logic                           M0_AXIS_TVALID,
  input  logic                           M0_AXIS_TREADY,
  output logic [VEC_W-1:0]               M0_AXIS_TDATA,
  output logic                           M0_AXIS_TLAST,
  output logic                           M1_AXIS_TVALID,
  input  logic                           M1_AXIS_TREADY,
  output logic [VEC_W-1:0]               M1_AXIS_TDATA,
  output logic                           M1_AXIS_TLAST,
  output logic                           ENG_RESET,
  output logic                           ENG_ENABLE,
  input  logic                           ENG_DONE,
  output logic [VEC_W-1:0]               TMS_VECTOR,
  output logic [VEC_W-1:0]               TDI_VECTOR,
  input  logic [VEC_W-1:0]               TDO_VECTOR,
  output logic [1:0]                     GRANT,
  output logic                           TIMEOUT_ERR,
  input  logic                           CLR_ERR
);

  localparam int                CNT_W   = (C_TIMEOUT_CYCLES > 2) ? $clog2(C_TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT_CYCLES - 1);

  logic [3:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [VEC_W-1:0] tms_r;
  logic [VEC_W-1:0] tdi_r;
  logic [VEC_W-1:0] tdo_r;
  logic             last_r;
  logic             err_r;

  logic             sel_valid;
  logic             sel;
  logic [1:0]       grant;
  logic             accept;
  logic [63:0]      cmd;
  logic             cmd_last;
  logic             resp_fire;
  logic             timeout_hit;

  jtag_rr_arb2 u_arb (
    .clk          (CLK),
    .resetn       (RESETN),
    .req          ({S1_AXIS_TVALID, S0_AXIS_TVALID}),
    .lock_set     (accept),
    .lock_release (resp_fire && last_r),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .grant        (grant)
  );

  assign accept      = (state == ST_IDLE) && sel_valid;
  assign cmd         = sel ? S1_AXIS_TDATA[63:0] : S0_AXIS_TDATA[63:0];
  assign cmd_last    = sel ? S1_AXIS_TLAST : S0_AXIS_TLAST;
  assign resp_fire   = (state == ST_RESP) &&
                       ((grant[0] && M0_AXIS_TREADY) || (grant[1] && M1_AXIS_TREADY));
  // DONE in the final counted cycle still wins over the timeout.
  assign timeout_hit = (state == ST_RUN) && !ENG_DONE && (cnt == CNT_LAST);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      tms_r  <= '0;
      tdi_r  <= '0;
      tdo_r  <= '0;
      last_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            tms_r  <= cmd[TMS_LSB +: VEC_W];
            tdi_r  <= cmd[TDI_LSB +: VEC_W];
            last_r <= cmd_last;
            state  <= ST_RST;
          end
        end
        ST_RST: begin
          cnt   <= '0;
          state <= ST_RUN;
        end
        ST_RUN: begin
          if (ENG_DONE) begin
            tdo_r <= TDO_VECTOR;
            state <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            tdo_r <= '0;
            state <= ST_RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_fire) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETN)          err_r <= 1'b0;
    else if (timeout_hit) err_r <= 1'b1;
    else if (CLR_ERR)     err_r <= 1'b0;
  end

  assign S0_AXIS_TREADY = accept && !sel;
  assign S1_AXIS_TREADY = accept && sel;
  assign ENG_RESET      = (state == ST_RST);
  assign ENG_ENABLE     = (state == ST_RUN);
  assign TMS_VECTOR     = tms_r;
  assign TDI_VECTOR     = tdi_r;
  assign M0_AXIS_TVALID = (state == ST_RESP) && grant[0];
  assign M1_AXIS_TVALID = (state == ST_RESP) && grant[1];
  assign M0_AXIS_TDATA  = tdo_r;
  assign M1_AXIS_TDATA  = tdo_r;
  assign M0_AXIS_TLAST  = last_r;
  assign M1_AXIS_TLAST  = last_r;
  assign GRANT          = grant;
  assign TIMEOUT_ERR    = err_r;

endmodule
